// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Round-robin owner of the single system memory bus. Requesters raise
//   in_reqcyc, receive a registered one-hot grant, then hold the bus by
//   asserting their in_busy bit until the transaction completes. Every
//   release is followed by a dead TURN cycle and an IDLE arbitration cycle,
//   so the bus driver always sees at least two grant-free cycles.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_reqcyc[N]        per-requester request level
//   in_busy[N]          per-requester busy; only the owner's bit moves the FSM
//   out_grant[N]        registered one-hot grant
//   out_owner           index of the current (or most recent) owner
//   out_bus_idle        no grant bit set
//   out_timeout         pulse in the last granted cycle of a grant that will
//                       be revoked for never asserting busy
//   out_busy_conflict   pulse, one cycle after a non-owner drove in_busy
module mem_bus_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int GRANT_TIMEOUT = 16,
   parameter int OWNER_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     in_reqcyc,
   input  logic [NUM_REQ-1:0]     in_busy,
   output logic [NUM_REQ-1:0]     out_grant,
   output logic [OWNER_WIDTH-1:0] out_owner,
   output logic                   out_bus_idle,
   output logic                   out_timeout,
   output logic                   out_busy_conflict
);

   localparam int WCW = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);
   localparam logic [OWNER_WIDTH-1:0] LAST_REQ = OWNER_WIDTH'(NUM_REQ - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_OWNED, ST_TURN} state_t;

   state_t                 state_q, state_d;
   logic [OWNER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [OWNER_WIDTH-1:0] owner_q, owner_d;
   logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic                   bus_idle_q, bus_idle_d;
   logic                   timeout_q, timeout_d;
   logic                   conflict_q, conflict_d;

   logic                   found;
   logic [OWNER_WIDTH-1:0] winner;
   logic [OWNER_WIDTH-1:0] scan_idx;

   // Cyclic first-set search starting at rr_ptr.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = (int'(rr_ptr_q) + i >= NUM_REQ) ? OWNER_WIDTH'(int'(rr_ptr_q) + i - NUM_REQ)
                                                    : OWNER_WIDTH'(int'(rr_ptr_q) + i);
         if (!found && in_reqcyc[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      wait_cnt_d = wait_cnt_q;
      grant_d    = '0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               owner_d  = winner;
               rr_ptr_d = (winner == LAST_REQ) ? '0 : winner + 1'b1;
               state_d  = ST_GRANTED;
            end
         end
         ST_GRANTED: begin
            // busy outranks withdrawal and timeout
            if (in_busy[owner_q])                                   state_d = ST_OWNED;
            else if (!in_reqcyc[owner_q])                           state_d = ST_TURN;
            else if (GRANT_TIMEOUT != 0 && wait_cnt_q == WAIT_LAST) state_d = ST_TURN;
            else                                                    wait_cnt_d = wait_cnt_q + 1'b1;
         end
         ST_OWNED: begin
            if (!in_busy[owner_q]) state_d = ST_TURN;
         end
         default: begin
            wait_cnt_d = '0;
            state_d    = ST_IDLE;
         end
      endcase
      if (state_d == ST_GRANTED || state_d == ST_OWNED) grant_d[owner_d] = 1'b1;
      bus_idle_d = ~|grant_d;
      // Registered one cycle early so the pulse lines up with the last
      // granted cycle; the revoke happens at the edge that ends it.
      timeout_d  = (GRANT_TIMEOUT != 0) && (state_d == ST_GRANTED) && (wait_cnt_d == WAIT_LAST);
      conflict_d = |(in_busy & ~grant_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         wait_cnt_q <= '0;
         grant_q    <= '0;
         bus_idle_q <= 1'b1;
         timeout_q  <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
         grant_q    <= grant_d;
         bus_idle_q <= bus_idle_d;
         timeout_q  <= timeout_d;
         conflict_q <= conflict_d;
      end
   end

   assign out_grant         = grant_q;
   assign out_owner         = owner_q;
   assign out_bus_idle      = bus_idle_q;
   assign out_timeout       = timeout_q;
   assign out_busy_conflict = conflict_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter (4 requesters, timeout 4). A transaction-level
// model (grant active / busy seen / age / cooldown) is stepped on every edge
// and compared to all outputs on every falling edge; directed phases add
// literal expectations, then a random phase exercises the rest.
module tb_mem_bus_arbiter;
   localparam int NR = 4;
   localparam int TO = 4;

   logic          clk, reset;
   logic [NR-1:0] in_reqcyc, in_busy;
   logic [NR-1:0] out_grant;
   logic [1:0]    out_owner;
   logic          out_bus_idle, out_timeout, out_busy_conflict;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(.NUM_REQ(NR), .GRANT_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .in_reqcyc(in_reqcyc), .in_busy(in_busy),
      .out_grant(out_grant), .out_owner(out_owner), .out_bus_idle(out_bus_idle),
      .out_timeout(out_timeout), .out_busy_conflict(out_busy_conflict));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      bit act;    // a grant is outstanding
      bit seen;   // owner has shown busy during this grant
      int owner;
      int age;    // cycles since grant without busy
      int cool;   // grant-free cycles left before arbitration may run
      int rr;
      bit to;
      bit conf;
   } mdl_t;

   mdl_t m;
   bit   m_valid = 1'b0;

   function automatic logic [NR-1:0] gvec(mdl_t s);
      return s.act ? NR'(1 << s.owner) : '0;
   endfunction

   function automatic mdl_t step_m(mdl_t s, bit rst, logic [NR-1:0] req, logic [NR-1:0] busy);
      mdl_t n;
      n = s;
      if (rst) begin
         n.act = 0; n.seen = 0; n.owner = 0; n.age = 0; n.cool = 0; n.rr = 0; n.to = 0; n.conf = 0;
         return n;
      end
      n.conf = |(busy & ~gvec(s));
      if (s.act) begin
         if (s.seen) begin
            if (!busy[s.owner]) begin n.act = 0; n.cool = 1; end
         end else if (busy[s.owner]) n.seen = 1;
         else if (!req[s.owner]) begin n.act = 0; n.cool = 1; end
         else if (s.age == TO - 1) begin n.act = 0; n.cool = 1; end
         else n.age = s.age + 1;
      end else if (s.cool > 0) begin
         n.cool = s.cool - 1;
      end else begin
         for (int k = 0; k < NR; k++) begin
            int c;
            c = (s.rr + k) % NR;
            if (!n.act && req[c]) begin
               n.act = 1; n.seen = 0; n.age = 0; n.owner = c; n.rr = (c + 1) % NR;
            end
         end
      end
      n.to = n.act && !n.seen && (n.age == TO - 1);
      return n;
   endfunction

   always @(posedge clk) begin
      m <= step_m(m, reset, in_reqcyc, in_busy);
      if (reset) m_valid <= 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_grant",    32'(out_grant),         32'(gvec(m)));
         chk("model_owner",    32'(out_owner),         32'(m.owner));
         chk("model_idle",     32'(out_bus_idle),      32'(!m.act));
         chk("model_timeout",  32'(out_timeout),       32'(m.to));
         chk("model_conflict", 32'(out_busy_conflict), 32'(m.conf));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_reqcyc = '0; in_busy = '0;
      step(); step();
      reset = 1'b0;
   endtask

   int exp_order [5] = '{0, 1, 2, 3, 0};
   int gap;
   int mode;

   initial begin
      reset = 1'b1; in_reqcyc = '0; in_busy = '0;
      step(); step();
      chk("reset_grant", 32'(out_grant), 32'h0);
      chk("reset_owner", 32'(out_owner), 32'h0);
      chk("reset_idle", 32'(out_bus_idle), 32'h1);
      chk("reset_timeout", 32'(out_timeout), 32'h0);
      reset = 1'b0;

      // single request, four busy cycles, release
      in_reqcyc = 4'b0010; step();
      chk("single_grant", 32'(out_grant), 32'h2);
      chk("single_owner", 32'(out_owner), 32'h1);
      in_busy = 4'b0010;
      repeat (4) step();
      chk("single_owned", 32'(out_grant), 32'h2);
      in_busy = '0; in_reqcyc = '0; step();
      chk("single_release", 32'(out_grant), 32'h0);
      chk("single_idle", 32'(out_bus_idle), 32'h1);
      step();

      // fairness: all request, each owner busy for two cycles
      do_reset();
      in_reqcyc = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         gap = 0;
         while (out_grant == '0 && gap < 20) begin step(); gap++; end
         chk("fair_owner", 32'(out_owner), 32'(exp_order[g]));
         if (g > 0) chk("fair_gap", 32'(gap), 32'd2);
         in_busy = out_grant; step(); step();
         in_busy = '0; step();
      end
      in_reqcyc = '0; step(); step();

      // timeout on bit 3, then bit 0 wins
      do_reset();
      in_reqcyc = 4'b1000; step();
      chk("to_grant", 32'(out_grant), 32'h8);
      step(); step();
      chk("to_no_pulse_yet", 32'(out_timeout), 32'h0);
      step();
      chk("to_pulse", 32'(out_timeout), 32'h1);
      chk("to_last_grant", 32'(out_grant), 32'h8);
      step();
      chk("to_revoked", 32'(out_grant), 32'h0);
      in_reqcyc = 4'b1001; step(); step();
      chk("to_next_owner", 32'(out_owner), 32'h0);
      chk("to_next_grant", 32'(out_grant), 32'h1);
      in_reqcyc = '0; step(); step(); step();

      // conflict while owner 2 waits, then withdrawal
      do_reset();
      in_reqcyc = 4'b0100; step();
      in_busy = 4'b0001; step();
      chk("conflict_pulse", 32'(out_busy_conflict), 32'h1);
      chk("conflict_owner", 32'(out_owner), 32'h2);
      in_busy = '0; step();
      chk("conflict_clear", 32'(out_busy_conflict), 32'h0);
      in_reqcyc = '0; step();
      chk("withdraw_grant", 32'(out_grant), 32'h0);
      chk("withdraw_no_to", 32'(out_timeout), 32'h0);
      step(); step();

      // reset while owned
      do_reset();
      in_reqcyc = 4'b0010; step();
      in_busy = 4'b0010; step(); step();
      reset = 1'b1; step();
      chk("rst_mid_grant", 32'(out_grant), 32'h0);
      chk("rst_mid_owner", 32'(out_owner), 32'h0);
      chk("rst_mid_idle", 32'(out_bus_idle), 32'h1);
      reset = 1'b0; in_busy = '0; in_reqcyc = 4'b0011; step();
      chk("rst_after_grant", 32'(out_grant), 32'h1);

      // random traffic; busy keenness alternates so timeouts also occur
      mode = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c % 150 == 0) mode = $urandom_range(0, 1);
         in_reqcyc = NR'($urandom) | NR'($urandom);
         in_busy   = ($urandom_range(0, 99) < (mode ? 8 : 70)) ? out_grant : '0;
         if ($urandom_range(0, 19) == 0) in_busy = in_busy | NR'(1 << $urandom_range(0, NR - 1));
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0; in_reqcyc = '0; in_busy = '0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
